unidade_controle_busca: RTL and testbench
=========================================

# unidade_controle_busca

Control unit that sits directly upstream of the counter/comparator datapath and sequences it. On a start request it clears the datapath counter, then counts it up until the comparator reports equality with the switch value. It stops with a "found" result on a match, a "not found" result if the counter wraps, or a "timeout" result after a bounded number of search cycles. The datapath's load control is tied inactive at the top level; this block drives only clear and count.

## Interface
- `MAX_CICLOS`, default 24: number of search cycles after which the search aborts with timeout; legal range 2..2^W_CICLOS-1.
- `W_CICLOS`, default 5: width of the internal search-cycle counter.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset; forces `inicial` and clears all registers.
- `iniciar`  in  1  start request, level input, edge-detected internally.
- `pausa`  in  1  while high in `busca`, withholds `conta` (the datapath counter holds); the cycle counter keeps running.
- `igual`  in  1  comparator A==B from the datapath.
- `fim`  in  1  counter ripple-carry from the datapath (conta && Q==15).
- `zera`  out  1  datapath counter synchronous clear.
- `conta`  out  1  datapath counter enable.
- `pronto`  out  1  search finished (any result).
- `achou`  out  1  result: match found.
- `nao_achou`  out  1  result: counter wrapped without a match.
- `estouro`  out  1  result: timeout.
- `db_estado`  out  4  current state code.
- `db_ciclos`  out  W_CICLOS  search-cycle count.

## Operation
- The start edge detector uses a register `iniciar_d`, which samples `iniciar` every clock.
- Start pulse is `inicio = iniciar & ~iniciar_d`. A held-high `iniciar` produces exactly one pulse.
- States and codes:
  - `inicial`=0000
  - `preparacao`=0001
  - `busca`=0010
  - `achou`=0100
  - `nao_achou`=0101
  - `estouro`=0110
  - All other codes go to `inicial` on the next edge.
- Transitions:
  - From `inicial`: `inicio` goes to `preparacao`; otherwise stay.
  - From `preparacao`: always go to `busca`.
  - From `busca`, in priority order:
    1. `igual` goes to `achou`.
    2. Else `fim` goes to `nao_achou`.
    3. Else `ciclos == MAX_CICLOS-1` goes to `estouro`.
    4. Else stay.
  - From `achou`, `nao_achou` and `estouro`: `inicio` goes to `preparacao`; otherwise hold.
  - `inicio` is ignored in `preparacao` and `busca`.
- Outputs:
  - `zera` = (estado==`preparacao`). Moore output.
  - `conta` = (estado==`busca`) & ~`pausa` & ~`igual`. Mealy output, so the counter freezes on the matching value.
  - `pronto` = 1 in `achou`, `nao_achou` and `estouro`.
  - `achou`, `nao_achou` and `estouro` are each 1 only in the state of the same name.
  - `db_estado` = state code.
- Cycle counter `ciclos`:
  - Clears to 0 in `preparacao`.
  - Increments by 1 on every edge taken while in `busca`, saturating at 2^W_CICLOS-1.
  - Holds in all other states.
  - `db_ciclos` = `ciclos`.
- Reset values: state `inicial`, `iniciar_d`=0, `ciclos`=0. Therefore every output is 0 and `db_estado`=0000.
- `reset` asserted mid-operation returns the block to `inicial` immediately, without waiting for a clock edge. The datapath counter value is not touched by this block.

## Timing
- With `iniciar` first sampled high at edge k:
  - State is `preparacao` after edge k.
  - State is `busca` after edge k+1, with the datapath counter at 0.
- Match with `chaves`=N, `pausa`=0:
  - `busca` lasts N+1 cycles, with the counter at Q=0..N.
  - State is `achou` after edge k+N+2.
  - The counter holds N.
  - `db_ciclos`=N+1.
- Wrap case (no match reached):
  - `fim` is high in the busca cycle where Q=15.
  - At that edge the state goes to `nao_achou` and the counter wraps to 0.
  - `db_ciclos`=16 when the search started from 0.
- Timeout: when neither `igual` nor `fim` occurs, `estouro` is entered after exactly MAX_CICLOS busca cycles, with `db_ciclos`=MAX_CICLOS.
- Simultaneous `igual` and `fim` cannot occur, because `conta` is gated by `igual`. `igual` has priority regardless.
- Restart from a result state costs the same latency as a start from `inicial`.

## Test plan
- Reset:
  - Stimulus: assert `reset` asynchronously mid-cycle.
  - Required response: all outputs 0 and `db_estado`=0000 before the next edge; `inicial` persists while `iniciar`=0.
- Match at 5:
  - Stimulus: `chaves`=5, one `iniciar` pulse.
  - Required response: states 0001, then 0010 for 6 cycles, then 0100; `achou`=`pronto`=1; counter=5; `db_ciclos`=6; `zera` high exactly 1 cycle.
- Match at 0:
  - Stimulus: `chaves`=0, start.
  - Required response: `conta` never asserts; `achou` after 1 busca cycle; `db_ciclos`=1; counter=0.
- Wrap to not-found:
  - Stimulus: `chaves`=10; change `chaves` to 2 when Q=5.
  - Required response: `nao_achou`=1 after the Q=15 cycle; counter=0; `db_ciclos`=16.
- Timeout:
  - Stimulus: `pausa`=1 throughout busca, `MAX_CICLOS`=24, `chaves`=7.
  - Required response: `conta` stays 0; `estouro`=1 after 24 busca cycles; `db_ciclos`=24.
- Start handling:
  - Stimulus: `iniciar` held high across a whole search.
  - Required response: exactly one search, with the block holding in the result state.
  - Stimulus: then drop `iniciar` and raise it again.
  - Required response: restart; `db_ciclos` clears in `preparacao`.
  - Stimulus: `reset` mid-busca.
  - Required response: immediate return to `inicial`.

Source files
------------

// File: rtl/unidade_controle_busca.sv
// rtl/unidade_controle_busca.sv - search sequencer for the counter/comparator datapath
//
// Purpose: on a rising edge of iniciar, clears the datapath counter, then counts it
// up until the comparator flags equality with the switches. The search ends with
// one of three results: found (igual), not found (counter wrapped, fim), or timeout
// (MAX_CICLOS search cycles elapsed). The datapath load control is not driven here.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   asynchronous active-high reset
//   iniciar    in   start request (level, edge-detected internally)
//   pausa      in   withholds conta while searching; cycle counter keeps running
//   igual      in   datapath comparator A==B
//   fim        in   datapath counter ripple-carry (conta && Q==15)
//   zera       out  datapath counter synchronous clear
//   conta      out  datapath counter enable
//   pronto     out  search finished, any result
//   achou      out  result: match found
//   nao_achou  out  result: counter wrapped without a match
//   estouro    out  result: timeout
//   db_estado  out  current state code
//   db_ciclos  out  search-cycle count

module unidade_controle_busca #(
  parameter int MAX_CICLOS = 24,
  parameter int W_CICLOS   = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                pausa,
  input  logic                igual,
  input  logic                fim,
  output logic                zera,
  output logic                conta,
  output logic                pronto,
  output logic                achou,
  output logic                nao_achou,
  output logic                estouro,
  output logic [3:0]          db_estado,
  output logic [W_CICLOS-1:0] db_ciclos
);

  typedef enum logic [3:0] {
    S_INICIAL    = 4'b0000,
    S_PREPARACAO = 4'b0001,
    S_BUSCA      = 4'b0010,
    S_ACHOU      = 4'b0100,
    S_NAO_ACHOU  = 4'b0101,
    S_ESTOURO    = 4'b0110
  } estado_t;

  // Last busca cycle before timeout; the transition edge brings ciclos to MAX_CICLOS.
  localparam logic [W_CICLOS-1:0] CICLOS_LIMITE = W_CICLOS'(MAX_CICLOS - 1);
  localparam logic [W_CICLOS-1:0] CICLOS_TETO   = {W_CICLOS{1'b1}};

  estado_t             estado_q, estado_d;
  logic                iniciar_d_q, iniciar_d_d;  // previous-cycle copy of iniciar
  logic [W_CICLOS-1:0] ciclos_q, ciclos_d;
  logic                inicio;

  // ---------------------------------------------------------------------------
  // State register and companion registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= S_INICIAL;
      iniciar_d_q <= 1'b0;
      ciclos_q    <= '0;
    end else begin
      estado_q    <= estado_d;
      iniciar_d_q <= iniciar_d_d;
      ciclos_q    <= ciclos_d;
    end
  end

  // A held-high iniciar yields a single one-cycle pulse.
  always_comb begin
    iniciar_d_d = iniciar;
    inicio      = iniciar & ~iniciar_d_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      S_INICIAL: begin
        if (inicio) estado_d = S_PREPARACAO;
      end
      S_PREPARACAO: begin
        estado_d = S_BUSCA;
      end
      S_BUSCA: begin
        // igual wins over fim; in practice they never coincide since conta is
        // gated by igual, so fim cannot fire on the matching value.
        if (igual)                         estado_d = S_ACHOU;
        else if (fim)                      estado_d = S_NAO_ACHOU;
        else if (ciclos_q == CICLOS_LIMITE) estado_d = S_ESTOURO;
      end
      S_ACHOU, S_NAO_ACHOU, S_ESTOURO: begin
        if (inicio) estado_d = S_PREPARACAO;
      end
      default: begin
        estado_d = S_INICIAL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Search-cycle counter: cleared while preparing, counts every busca edge
  // (including the one leaving busca), saturates at all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    ciclos_d = ciclos_q;
    if (estado_q == S_PREPARACAO) begin
      ciclos_d = '0;
    end else if (estado_q == S_BUSCA && ciclos_q != CICLOS_TETO) begin
      ciclos_d = ciclos_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    zera      = 1'b0;
    conta     = 1'b0;
    pronto    = 1'b0;
    achou     = 1'b0;
    nao_achou = 1'b0;
    estouro   = 1'b0;
    case (estado_q)
      S_PREPARACAO: zera = 1'b1;
      // Mealy on igual so the datapath counter freezes on the matching value.
      S_BUSCA:      conta = ~pausa & ~igual;
      S_ACHOU: begin
        pronto = 1'b1;
        achou  = 1'b1;
      end
      S_NAO_ACHOU: begin
        pronto    = 1'b1;
        nao_achou = 1'b1;
      end
      S_ESTOURO: begin
        pronto  = 1'b1;
        estouro = 1'b1;
      end
      default: ;
    endcase
    db_estado = estado_q;
    db_ciclos = ciclos_q;
  end

endmodule

// File: tb/tb_unidade_controle_busca.sv
// tb/tb_unidade_controle_busca.sv - self-checking bench for unidade_controle_busca

module tb_unidade_controle_busca;

  localparam int MAX = 24;
  localparam int W   = 5;

  logic         clock   = 1'b0;
  logic         reset   = 1'b0;
  logic         iniciar = 1'b0;
  logic         pausa   = 1'b0;
  logic         igual;
  logic         fim;
  logic         zera, conta, pronto, achou, nao_achou, estouro;
  logic [3:0]   db_estado;
  logic [W-1:0] db_ciclos;

  logic [3:0]   chaves = 4'd0;
  logic [3:0]   dp_q   = 4'd0;

  int n_vec = 0;
  int n_err = 0;
  int m_q   = 0;   // expected datapath counter value
  int m_cyc = 0;   // expected search-cycle count

  unidade_controle_busca #(
    .MAX_CICLOS (MAX),
    .W_CICLOS   (W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .pausa     (pausa),
    .igual     (igual),
    .fim       (fim),
    .zera      (zera),
    .conta     (conta),
    .pronto    (pronto),
    .achou     (achou),
    .nao_achou (nao_achou),
    .estouro   (estouro),
    .db_estado (db_estado),
    .db_ciclos (db_ciclos)
  );

  always #5 clock = ~clock;

  // Datapath environment: 4-bit counter with clear/enable and comparator.
  always @(posedge clock) begin
    if (zera)       dp_q <= 4'd0;
    else if (conta) dp_q <= dp_q + 4'd1;
  end
  assign igual = (dp_q == chaves);
  assign fim   = conta && (dp_q == 4'd15);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // st: expected state code; flags follow from it by definition of each state.
  task automatic chk_all(input string tag, input int st, input bit e_conta,
                         input int cyc, input int q);
    chk({tag, ".estado"},    32'(db_estado), st);
    chk({tag, ".zera"},      32'(zera),      32'(st == 1));
    chk({tag, ".conta"},     32'(conta),     32'(e_conta));
    chk({tag, ".pronto"},    32'(pronto),    32'(st == 4 || st == 5 || st == 6));
    chk({tag, ".achou"},     32'(achou),     32'(st == 4));
    chk({tag, ".nao_achou"}, 32'(nao_achou), 32'(st == 5));
    chk({tag, ".estouro"},   32'(estouro),   32'(st == 6));
    chk({tag, ".db_ciclos"}, 32'(db_ciclos), cyc);
    chk({tag, ".dp_q"},      32'(dp_q),      q);
  endtask

  // One complete search. chg_q/chg_v: switch value changes to chg_v once Q reaches
  // chg_q (-1 = never). abort_at: busca cycle index at which reset is pulsed (-1 = never).
  task automatic run_search(input int ch, input int pprob, input int chg_q, input int chg_v,
                            input bit hold, input bit toggle, input int abort_at);
    int  res;
    int  cur;
    int  it;
    bit  e_conta;
    chaves  = 4'(ch);
    pausa   = 1'b0;
    iniciar = 1'b0;
    tick();
    iniciar = 1'b1;
    tick();
    #2;
    chk_all("prep", 1, 1'b0, m_cyc, m_q);
    if (!hold) iniciar = 1'b0;
    tick();
    m_q   = 0;
    m_cyc = 0;
    res   = 2;
    it    = 0;
    while (res == 2) begin
      if (m_q == chg_q) chaves = 4'(chg_v);
      cur   = int'(chaves);
      pausa = ($urandom_range(99) < pprob);
      if (toggle && !hold) iniciar = 1'($urandom_range(1));
      #2;
      e_conta = !pausa && (m_q != cur);
      chk_all("busca", 2, e_conta, m_cyc, m_q);
      if (it == abort_at) begin
        #1 reset = 1'b1;
        #1;
        m_cyc = 0;
        chk_all("reset_async", 0, 1'b0, 0, m_q);
        tick();
        reset   = 1'b0;
        iniciar = 1'b0;
        pausa   = 1'b0;
        repeat (3) begin
          tick();
          #2;
          chk_all("idle_after_reset", 0, 1'b0, 0, m_q);
        end
        return;
      end
      if (m_q == cur)                  res = 4;
      else if (e_conta && m_q == 15)   res = 5;
      else if (m_cyc == MAX - 1)       res = 6;
      m_cyc++;
      if (e_conta) m_q = (m_q + 1) % 16;
      it++;
      tick();
    end
    pausa = 1'b0;
    if (!hold) iniciar = 1'b0;
    #2;
    chk_all("result", res, 1'b0, m_cyc, m_q);
    repeat (2) begin
      tick();
      #2;
      chk_all("result_hold", res, 1'b0, m_cyc, m_q);
    end
  endtask

  initial begin
    int pp[4];
    pp[0] = 0; pp[1] = 25; pp[2] = 60; pp[3] = 100;

    // Power-on reset
    #1 reset = 1'b1;
    #2;
    chk_all("por", 0, 1'b0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (3) begin
      tick();
      #2;
      chk_all("idle", 0, 1'b0, 0, 0);
    end

    // Directed searches
    run_search(5, 0, -1, 0, 1'b0, 1'b0, -1);    // match at 5
    run_search(0, 0, -1, 0, 1'b0, 1'b0, -1);    // match at 0
    run_search(10, 0, 5, 2, 1'b0, 1'b0, -1);    // wrap to not-found
    run_search(7, 100, -1, 0, 1'b0, 1'b0, -1);  // timeout with pausa held
    run_search(9, 0, -1, 0, 1'b1, 1'b0, -1);    // iniciar held across search
    run_search(3, 0, -1, 0, 1'b0, 1'b0, -1);    // restart from result state
    run_search(12, 0, -1, 0, 1'b0, 1'b0, 4);    // reset mid-busca
    run_search(2, 0, -1, 0, 1'b0, 1'b0, -1);    // clean search after reset

    // Randomized searches
    for (int i = 0; i < 24; i++) begin
      int ch;
      int cq;
      int cv;
      int ab;
      ch = int'($urandom_range(15));
      cq = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1;
      cv = int'($urandom_range(15));
      ab = ($urandom_range(7) == 0) ? int'($urandom_range(5)) : -1;
      run_search(ch, pp[$urandom_range(3)], cq, cv, 1'b0, 1'b1, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
